// File: rtl/alu_bist.sv
// Built-in self-test controller for the 32-bit ALU: drives LFSR operand pairs through
// all nine opcodes, checks r/z against a golden model, and records the first mismatch.
module alu_bist #(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [3:0]  fail_aluc,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic [31:0] fail_r
);

  // An all-zero Galois LFSR would lock up, so a zero seed runs as 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [3:0] op_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0000;
      4'd1:    return 4'b0100;
      4'd2:    return 4'b0001;
      4'd3:    return 4'b0101;
      4'd4:    return 4'b0010;
      4'd5:    return 4'b0110;
      4'd6:    return 4'b0011;
      4'd7:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return {b[15:0], 16'h0};
      4'b0011: return b << a[4:0];
      4'b0111: return b >> a[4:0];
      4'b1111: return 32'($signed(b) >>> a[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  state_t      r_state;
  logic [31:0] r_lfsr;
  logic [15:0] r_vec;
  logic [3:0]  r_op;
  logic [31:0] r_samp_r;
  logic        r_samp_z;

  logic [31:0] w_src;
  logic [31:0] w_va;
  logic [31:0] w_vb;
  logic [31:0] w_gold;
  logic        w_mismatch;
  logic [15:0] w_err_next;

  // A fresh run restarts the sequence from the seed; later vectors continue from r_lfsr.
  assign w_src      = (r_state == S_CHECK) ? r_lfsr : SEED_EFF;
  assign w_va       = lfsr_step(w_src);
  assign w_vb       = lfsr_step(w_va);
  assign w_gold     = golden(alu_a, alu_b, alu_aluc);
  assign w_mismatch = (r_samp_r != w_gold) || (r_samp_z != (w_gold == 32'h0));
  assign w_err_next = (w_mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 32'h0;
      r_vec     <= 16'h0;
      r_op      <= 4'h0;
      r_samp_r  <= 32'h0;
      r_samp_z  <= 1'b0;
      alu_a     <= 32'h0;
      alu_b     <= 32'h0;
      alu_aluc  <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 16'h0;
      fail_aluc <= 4'h0;
      fail_a    <= 32'h0;
      fail_b    <= 32'h0;
      fail_r    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= 16'h0;
            fail_aluc <= 4'h0;
            fail_a    <= 32'h0;
            fail_b    <= 32'h0;
            fail_r    <= 32'h0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            r_vec     <= 16'h0;
            r_op      <= 4'h0;
            alu_a     <= w_va;
            alu_b     <= w_vb;
            alu_aluc  <= op_code(4'd0);
            r_lfsr    <= w_vb;
            r_state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_samp_r <= alu_r;
          r_samp_z <= alu_z;
          r_state  <= S_CHECK;
        end
        S_CHECK: begin
          err_count <= w_err_next;
          if (w_mismatch && err_count == 16'h0) begin
            fail_aluc <= alu_aluc;
            fail_a    <= alu_a;
            fail_b    <= alu_b;
            fail_r    <= r_samp_r;
          end
          if (r_op != 4'd8) begin
            r_op     <= r_op + 4'd1;
            alu_aluc <= op_code(r_op + 4'd1);
            r_state  <= S_DRIVE;
          end else if (r_vec != LAST_VEC) begin
            r_vec    <= r_vec + 16'd1;
            r_op     <= 4'h0;
            alu_a    <= w_va;
            alu_b    <= w_vb;
            alu_aluc <= op_code(4'd0);
            r_lfsr   <= w_vb;
            r_state  <= S_DRIVE;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_next == 16'h0);
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: three instances (1 vector seed 1, 4 vectors seed 1, 1 vector seed 0)
// beside a behavioural ALU with selectable faults; run results go through a scoreboard.
module tb_alu_bist;

  typedef struct {
    int          exp_cyc;
    logic [15:0] err;
    logic        pass;
    logic [3:0]  faluc;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] fr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   alu_mode = 0;  // 0 correct, 1 sub returns a+b, 2 forced r=0 z=1

  exp_t q1[$];
  exp_t q4[$];
  exp_t q0[$];

  logic        start1 = 1'b0, start4 = 1'b0, start0 = 1'b0;
  logic [31:0] alu_a1, alu_b1, alu_r1, alu_a4, alu_b4, alu_r4, alu_a0, alu_b0, alu_r0;
  logic [3:0]  alu_aluc1, alu_aluc4, alu_aluc0;
  logic        alu_z1, alu_z4, alu_z0;
  logic        busy1, done1, pass1, busy4, done4, pass4, busy0, done0, pass0;
  logic [15:0] err1, err4, err0;
  logic [3:0]  faluc1, faluc4, faluc0;
  logic [31:0] fa1, fb1, fr1, fa4, fb4, fr4, fa0, fb0, fr0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] tb_step(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  function automatic logic [31:0] tb_golden(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [63:0] ext;
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return {b[15:0], 16'h0};
      4'b0011: return b << a[4:0];
      4'b0111: return b >> a[4:0];
      4'b1111: begin
        ext = {{32{b[31]}}, b} >> a[4:0];
        return ext[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [32:0] tb_alu(input int mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    if (mode == 2) return {1'b1, 32'h0};
    r = (mode == 1 && op == 4'b0100) ? a + b : tb_golden(a, b, op);
    return {r == 32'h0, r};
  endfunction

  // Number of ops whose golden result is non-zero over nv vectors from seed 1.
  function automatic int forced_zero_errors(input int nv);
    logic [3:0]  ops [9] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                             4'b0110, 4'b0011, 4'b0111, 4'b1111};
    logic [31:0] s, a, b;
    int          n;
    s = 32'h1;
    n = 0;
    for (int v = 0; v < nv; v++) begin
      a = tb_step(s);
      b = tb_step(a);
      s = b;
      for (int k = 0; k < 9; k++)
        if (tb_golden(a, b, ops[k]) != 32'h0) n++;
    end
    return n;
  endfunction

  assign {alu_z1, alu_r1} = tb_alu(alu_mode, alu_a1, alu_b1, alu_aluc1);
  assign {alu_z4, alu_r4} = tb_alu(alu_mode, alu_a4, alu_b4, alu_aluc4);
  assign {alu_z0, alu_r0} = tb_alu(alu_mode, alu_a0, alu_b0, alu_aluc0);

  alu_bist #(.NUM_VECTORS(1), .SEED(32'h1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_aluc(alu_aluc1), .alu_r(alu_r1), .alu_z(alu_z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_aluc(faluc1), .fail_a(fa1), .fail_b(fb1), .fail_r(fr1));

  alu_bist #(.NUM_VECTORS(4), .SEED(32'h1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_aluc(alu_aluc4), .alu_r(alu_r4), .alu_z(alu_z4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .fail_aluc(faluc4), .fail_a(fa4), .fail_b(fb4), .fail_r(fr4));

  alu_bist #(.NUM_VECTORS(1), .SEED(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_aluc(alu_aluc0), .alu_r(alu_r0), .alu_z(alu_z0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_aluc(faluc0), .fail_a(fa0), .fail_b(fb0), .fail_r(fr0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_run(input string tag, input exp_t e, input logic [15:0] err,
                         input logic pass, input logic busy, input logic [3:0] faluc,
                         input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fr);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.exp_cyc));
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err_count"}, 32'(err), 32'(e.err));
    check({tag, "_pass"}, 32'(pass), 32'(e.pass));
    check({tag, "_fail_aluc"}, 32'(faluc), 32'(e.faluc));
    check({tag, "_fail_a"}, fa, e.fa);
    check({tag, "_fail_b"}, fb, e.fb);
    check({tag, "_fail_r"}, fr, e.fr);
  endtask

  // Monitors: one per instance, comparing each completed run against the queue head.
  logic done1_d = 1'b0, done4_d = 1'b0, done0_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !done1_d) begin
      if (q1.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut1_unexpected_done: got done=1 expected no run pending");
      end else begin
        e = q1.pop_front();
        cmp_run("dut1", e, err1, pass1, busy1, faluc1, fa1, fb1, fr1);
      end
    end
    done1_d = done1;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done4 && !done4_d) begin
      if (q4.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut4_unexpected_done: got done=1 expected no run pending");
      end else begin
        e = q4.pop_front();
        cmp_run("dut4", e, err4, pass4, busy4, faluc4, fa4, fb4, fr4);
      end
    end
    done4_d = done4;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !done0_d) begin
      if (q0.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut0_unexpected_done: got done=1 expected no run pending");
      end else begin
        e = q0.pop_front();
        cmp_run("dut0", e, err0, pass0, busy0, faluc0, fa0, fb0, fr0);
      end
    end
    done0_d = done0;
  end

  // Pulses start on one instance; returns the cycle number of the accepting edge.
  task automatic pulse(input int which, output int t0);
    @(negedge clk);
    case (which)
      1: start1 = 1'b1;
      4: start4 = 1'b1;
      default: start0 = 1'b1;
    endcase
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    start0 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int which, input int budget);
    int   n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < budget) begin
      @(negedge clk);
      d = (which == 1) ? done1 : (which == 4) ? done4 : done0;
      n++;
    end
    if (!d) begin
      n_checks++; n_err++;
      $display("FAIL timeout_dut%0d: got no done expected done within %0d cycles", which, budget);
    end
    @(negedge clk);
  endtask

  function automatic exp_t good_run(input int t0, input int nv);
    exp_t e;
    e = '{exp_cyc: t0 + 18 * nv, err: 16'h0, pass: 1'b1, faluc: 4'h0,
          fa: 32'h0, fb: 32'h0, fr: 32'h0};
    return e;
  endfunction

  initial begin
    int   t0;
    exp_t e;
    int   nforced;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_done", 32'(done1), 32'h0);
    check("rst_pass", 32'(pass1), 32'h0);
    check("rst_err", 32'(err1), 32'h0);
    check("rst_alu_a", alu_a1, 32'h0);
    rst = 1'b0;

    // Correct ALU; also checks first drive, op stability and a start while busy.
    alu_mode = 0;
    pulse(1, t0);
    q1.push_back(good_run(t0, 1));
    check("busy_after_start", 32'(busy1), 32'h1);
    check("first_a", alu_a1, 32'h8020_0003);
    check("first_b", alu_b1, 32'hC030_0002);
    check("first_aluc", 32'(alu_aluc1), 32'h0);
    @(negedge clk);
    check("aluc_held", 32'(alu_aluc1), 32'h0);
    @(negedge clk);
    check("second_aluc", 32'(alu_aluc1), 32'h4);
    check("a_held_sub", alu_a1, 32'h8020_0003);
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1, 40);

    // Faulty sub; the start from DONE must clear done and pass at once.
    alu_mode = 1;
    pulse(1, t0);
    check("start_in_done_done", 32'(done1), 32'h0);
    check("start_in_done_pass", 32'(pass1), 32'h0);
    e = '{exp_cyc: t0 + 18, err: 16'd1, pass: 1'b0, faluc: 4'b0100,
          fa: 32'h8020_0003, fb: 32'hC030_0002, fr: 32'h4050_0005};
    q1.push_back(e);
    wait_done(1, 40);

    // Reset seven cycles into a run, then a clean rerun.
    alu_mode = 0;
    pulse(1, t0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_all_zero",
          32'(|{busy1, done1, pass1, err1, faluc1, fa1, fb1, fr1, alu_a1, alu_b1, alu_aluc1}),
          32'h0);
    check("midrst_busy", 32'(busy1), 32'h0);
    rst = 1'b0;
    pulse(1, t0);
    q1.push_back(good_run(t0, 1));
    wait_done(1, 40);

    // Stuck-at-zero ALU over four vectors.
    alu_mode = 2;
    nforced = forced_zero_errors(4);
    pulse(4, t0);
    e = '{exp_cyc: t0 + 72, err: 16'(nforced), pass: (nforced == 0), faluc: 4'b0000,
          fa: 32'h8020_0003, fb: 32'hC030_0002, fr: 32'h0};
    q4.push_back(e);
    wait_done(4, 100);

    // Zero seed behaves exactly like seed 1.
    alu_mode = 0;
    pulse(0, t0);
    q0.push_back(good_run(t0, 1));
    check("seed0_first_a", alu_a0, 32'h8020_0003);
    check("seed0_first_b", alu_b0, 32'hC030_0002);
    wait_done(0, 40);

    check("scoreboard_drained", 32'(q1.size() + q4.size() + q0.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test controller for the 32-bit ALU. On a start pulse it generates pseudo-random operand pairs, drives each pair through all nine ALU operations, and samples `r`/`z` one cycle later. It compares them against an internal golden model and reports an error count plus the first failing vector. It sits beside the ALU, owning its `a`/`b`/`aluc` inputs during test and consuming `r`/`z`.

## Interface
- `NUM_VECTORS`, default 16: operand pairs per run (1..65535).
- `SEED`, default 32'h00000001: LFSR seed; 0 is replaced by 1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `start` in 1: one-cycle run request.
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `alu_aluc` out 4: ALU opcode.
- `alu_r` in 32: ALU result.
- `alu_z` in 1: ALU zero flag.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until the next accepted start.
- `pass` out 1: done and err_count==0.
- `err_count` out 16: mismatching operations; saturates at 16'hFFFF.
- `fail_aluc`, `fail_a`, `fail_b`, `fail_r` out 4/32/32/32: first mismatch record.

## Operation
- Opcode order per vector: 0000 add, 0100 sub, 0001 and, 0101 or, 0010 xor, 0110 lui, 0011 sll, 0111 srl, 1111 sra.
- Golden model, all mod 2^32:
  - add: a+b; sub: a-b; and, or and xor are bitwise.
  - lui: {b[15:0],16'h0}.
  - sll: b<<a[4:0]; srl: logical b>>a[4:0]; sra: arithmetic b>>>a[4:0].
  - z: golden result==0.
- Mismatch: alu_r≠golden or alu_z≠golden z. Each op counts once.
- LFSR: 32-bit Galois. step(s) = {1'b0,s[31:1]} ^ (s[0] ? 32'h80200003 : 0).
  - Each vector: a=step(lfsr), b=step(a), then lfsr←b.
  - The run starts with lfsr=SEED.
- States:
  - IDLE: on start, clear counters and fail record, load vector 0 op 0 onto alu_*, go to DRIVE, busy=1.
  - DRIVE: ALU settles; at the edge register alu_r/alu_z and go to CHECK.
  - CHECK: compare the registered sample against golden(alu_a, alu_b, alu_aluc).
    - On mismatch: increment err_count (saturating). If it is the first error, latch fail_*, with fail_r = the sampled alu_r.
    - Then advance to the next op (or the next vector, op 0) and go to DRIVE.
    - After the last op of the last vector, go to DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). alu_* hold their last values. On start, behave as from IDLE.
- start while busy: ignored.
- rst, including mid-run: next cycle state is IDLE and every output is 0.

## Timing
- Reset values: all outputs 0, including pass and done.
- alu_* change only on edges entering DRIVE and are stable for 2 cycles per op.
- Start accepted at edge t0 → busy=1 and vector 0 op 0 on alu_* after t0.
- done=1 and busy=0 after edge t0+18·NUM_VECTORS.
- err_count and fail_* update at the CHECK-exit edge of the failing op.
- Start accepted in DONE: done and pass drop to 0 at that edge.

## Test plan
- Correct ALU model, NUM_VECTORS=1, SEED=1:
  - First drive is a=0x80200003, b=0xC0300002, aluc=0000.
  - add expects r=0x40500005; sub expects 0xBFF00001.
  - done 18 cycles after start, pass=1, err_count=0.
- Faulty ALU where sub returns a+b, same params:
  - err_count=1, fail_aluc=0100, fail_a=0x80200003, fail_b=0xC0300002, fail_r=0x40500005, pass=0.
- ALU forced r=0, z=1, NUM_VECTORS=4: err_count=36, fail_aluc=0000, fail_r=0.
- rst asserted 7 cycles after start:
  - All outputs 0 on the next cycle.
  - A new start then reproduces the first scenario's results exactly.
- start pulsed while busy: no effect, done timing unchanged.
- start pulsed in DONE: done and pass clear, then rerun gives identical results.
- SEED=0: a/b sequence and results identical to SEED=1.
